pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage 64-bit ARM pipeline (IF, RF, EX, MEM, WB). Detects load-use and flag-use hazards between the RF and EX stages and freezes PC and IF/RF while injecting a bubble into RF/EX. Runs a halt/drain state machine so a debug host can stop the core cleanly and resume it. Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs, halt/debug controls and pipeline
// control outputs for pipe_hazard_ctrl. "master" drives the inputs; "slave" is the controller.
interface pipe_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             id_rn;
  logic [4:0]             id_rm;
  logic                   id_uses_rn;
  logic                   id_uses_rm;
  logic                   id_cond_br;
  logic                   br_taken;
  logic                   ex_read_en;
  logic [4:0]             ex_rd;
  logic                   ex_flag_set;
  logic                   halt_req;
  logic                   resume;
  logic                   stat_clr;
  logic                   pc_write_en;
  logic                   ifrf_write_en;
  logic                   ifrf_flush;
  logic                   rfex_bubble;
  logic                   halted;
  logic [STALL_CNT_W-1:0] stall_count;
  logic [1:0]             dbg_state;

  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm, id_cond_br, br_taken,
           ex_read_en, ex_rd, ex_flag_set, halt_req, resume, stat_clr,
    input  pc_write_en, ifrf_write_en, ifrf_flush, rfex_bubble, halted,
           stall_count, dbg_state
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm, id_cond_br, br_taken,
           ex_read_en, ex_rd, ex_flag_set, halt_req, resume, stat_clr,
    output pc_write_en, ifrf_write_en, ifrf_flush, rfex_bubble, halted,
           stall_count, dbg_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / flag-use hazard detection, halt/drain FSM and saturating stall counter
// for the 5-stage pipeline. Optional feature macro: PIPE_HAZARD_BR_FLUSH_EN (squash IF on taken branch).
module pipe_hazard_ctrl #(
  parameter int STALL_CNT_W  = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input logic             clk,
  input logic             reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             drain_q, drain_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic load_use;
  logic flag_use;
  logic hazard;
  logic pc_en;
  logic ifrf_en;
  logic flush;
  logic bubble;
  logic halted;

  // XZR is never written, so a load targeting X31 cannot create a dependency.
  assign load_use = bus.ex_read_en && (bus.ex_rd != 5'd31) &&
                    ((bus.id_uses_rn && (bus.id_rn == bus.ex_rd)) ||
                     (bus.id_uses_rm && (bus.id_rm == bus.ex_rd)));
  assign flag_use = bus.id_cond_br && bus.ex_flag_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    hazard  = 1'b0;
    pc_en   = 1'b1;
    ifrf_en = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        hazard = load_use || flag_use;
        if (hazard) begin
          pc_en   = 1'b0;
          ifrf_en = 1'b0;
          bubble  = 1'b1;
        end else if (bus.halt_req && !bus.br_taken) begin
          // Freeze PC now and discard the IF word; it is refetched after resume.
          state_d = ST_DRAIN;
          drain_d = 4'(DRAIN_CYCLES - 1);
          pc_en   = 1'b0;
          flush   = 1'b1;
        end
`ifdef PIPE_HAZARD_BR_FLUSH_EN
        else if (bus.br_taken) begin
          flush = 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        pc_en = 1'b0;
        flush = 1'b1;
        if (drain_q == 4'd0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      ST_HALTED: begin
        pc_en  = 1'b0;
        flush  = 1'b1;
        halted = 1'b1;
        if (bus.resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        drain_d = 4'd0;
      end
    endcase
  end

  // Clear wins over counting; the count sticks at all-ones once saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (bus.stat_clr) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign bus.pc_write_en   = pc_en;
  assign bus.ifrf_write_en = ifrf_en;
  assign bus.ifrf_flush    = flush;
  assign bus.rfex_bubble   = bubble;
  assign bus.halted        = halted;
  assign bus.stall_count   = stall_q;
  assign bus.dbg_state     = state_q;

endmodule
